mem_word_seq: RTL and testbench
===============================

MEM_WORD_SEQ -- requirements
Module: mem_word_seq

Interface
REQ-001 Parameter ADDR_BITS, default 8, SHALL set the byte-address width of the memory port.
REQ-002 Parameter NBYTES, default 4, legal 1..4, SHALL set the bytes per word transfer; the word width is 8*NBYTES.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  1  requester has a transfer pending.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_write  input  1  1 = word write, 0 = word read.
REQ-008 req_addr  input  ADDR_BITS  byte address of the word's byte 0; no alignment required.
REQ-009 req_wdata  input  8*NBYTES  write data; byte i = bits [8i+7:8i].
REQ-010 resp_valid  output  1  one-cycle pulse marking transfer completion.
REQ-011 resp_rdata  output  8*NBYTES  assembled word; byte i from address base+i.
REQ-012 mem_en  output  1  byte-memory enable.
REQ-013 mem_write  output  1  byte-memory write strobe.
REQ-014 mem_adr  output  ADDR_BITS  byte-memory address.
REQ-015 mem_wdata  output  8  byte-memory write data.
REQ-016 mem_rdata  input  8  byte-memory read data; the memory samples mem_en/mem_write/mem_adr/mem_wdata on the falling clk edge and updates mem_rdata on that same edge with the pre-write contents.

Function
REQ-017 FSM states SHALL be IDLE, XFER, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where req_valid && req_ready.
REQ-019 On acceptance the block SHALL register req_addr, req_write, req_wdata, clear byte index idx to 0, and enter XFER.
REQ-020 In XFER, outputs SHALL be driven from registers only: mem_en=1, mem_write=stored write flag, mem_adr=(base+idx) mod 2^ADDR_BITS, mem_wdata=stored byte idx.
REQ-021 On each rising edge in XFER, mem_rdata SHALL be captured into resp_rdata byte idx, and idx SHALL increment.
REQ-022 After capturing byte NBYTES-1, the FSM SHALL enter RESP; one byte per clock, no wait states.
REQ-023 In RESP, resp_valid=1 for exactly one cycle; the next state is always IDLE.
REQ-024 Latency: with acceptance at edge T, mem_en SHALL be high for cycles T..T+NBYTES-1; resp_valid high in the cycle after edge T+NBYTES; req_ready high again after edge T+NBYTES+1.
REQ-025 Address wrap: base+idx SHALL wrap modulo 2^ADDR_BITS (e.g. base 0xFE gives 0xFE,0xFF,0x00,0x01).
REQ-026 Write transfers SHALL also capture mem_rdata, so resp_rdata returns the pre-write word.
REQ-027 In IDLE and RESP, mem_en, mem_write, mem_adr and mem_wdata SHALL be 0.
REQ-028 resp_rdata SHALL hold its value from RESP until the first byte capture of the next transfer.
REQ-029 Changes to req_* inputs after acceptance SHALL NOT affect the transfer in flight.
REQ-030 req_valid held high through completion SHALL be accepted again in the first IDLE cycle (back-to-back period NBYTES+2 cycles).

Reset
REQ-031 While reset_n=0: state IDLE, idx=0, req_ready=1, resp_valid=0, resp_rdata=0, and all mem_* outputs 0, applied asynchronously.
REQ-032 Reset during XFER SHALL drop mem_en immediately; bytes already written stay in memory; no resp_valid is produced for the aborted transfer.
REQ-033 First acceptance is possible on the first rising edge after reset_n deasserts.

Verification
REQ-034 Memory bytes 0x10..0x13 = 0x11,0x22,0x33,0x44; read at 0x10 -> resp_rdata=0x44332211, resp_valid one cycle after the fourth mem_en cycle.
REQ-035 Write 0xDEADBEEF at 0x20 over zeros, then read 0x20 -> write resp_rdata=0x00000000; memory 0x20..0x23 = EF,BE,AD,DE; read returns 0xDEADBEEF.
REQ-036 Read at 0xFE with bytes FE=01, FF=02, 00=03, 01=04 -> mem_adr sequence FE,FF,00,01; resp_rdata=0x04030201.
REQ-037 req_valid held high for two reads -> accepts 6 cycles apart; req_ready=0 in every intervening cycle; req_addr changed mid-transfer has no effect.
REQ-038 reset_n pulled low after the second byte of a write of 0xAABBCCDD at 0x40 -> mem_en=0 at once; no resp_valid; memory 0x40=DD, 0x41=CC, 0x42..0x43 unchanged; a later read succeeds.

Source files
------------

// File: rtl/mem_word_seq_if.sv
// ---------------------------------------------------------------------------
// mem_word_seq_if
//
// Purpose:
//   Bundles the word-request handshake, the completion response and the
//   byte-wide memory port of mem_word_seq into one interface.
//
// Signals:
//   req_valid / req_ready        request handshake (accepted when both high)
//   req_write                    1 = word write, 0 = word read
//   req_addr   [ADDR_BITS-1:0]   byte address of byte 0 of the word
//   req_wdata  [8*NBYTES-1:0]    write data, byte i = bits [8i+7:8i]
//   resp_valid                   one-cycle completion pulse
//   resp_rdata [8*NBYTES-1:0]    assembled word, byte i from base+i
//   mem_en / mem_write           byte-memory enable and write strobe
//   mem_adr    [ADDR_BITS-1:0]   byte-memory address
//   mem_wdata  [7:0]             byte-memory write data
//   mem_rdata  [7:0]             byte-memory read data (pre-write contents)
//
// Modports:
//   slave  - the sequencer itself
//   master - the environment: requester plus byte memory
// ---------------------------------------------------------------------------
interface mem_word_seq_if #(
    parameter int ADDR_BITS = 8,
    parameter int NBYTES    = 4
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [ADDR_BITS-1:0]   req_addr;
    logic [8*NBYTES-1:0]    req_wdata;

    logic                   resp_valid;
    logic [8*NBYTES-1:0]    resp_rdata;

    logic                   mem_en;
    logic                   mem_write;
    logic [ADDR_BITS-1:0]   mem_adr;
    logic [7:0]             mem_wdata;
    logic [7:0]             mem_rdata;

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output mem_en,
        output mem_write,
        output mem_adr,
        output mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  mem_en,
        input  mem_write,
        input  mem_adr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_word_seq.sv
// ---------------------------------------------------------------------------
// mem_word_seq
//
// Purpose:
//   Turns a single word request (read or write of NBYTES bytes at an
//   arbitrary, unaligned byte address) into NBYTES back-to-back accesses on
//   a byte-wide memory, one byte per clock. Every transfer also collects the
//   bytes the memory returns, so a write reports the word it overwrote.
//
// Ports:
//   clk      rising-edge clock for all state
//   reset_n  asynchronous, active-low reset
//   bus      mem_word_seq_if.slave: request handshake, response, memory port
//
// Timing (acceptance on rising edge T):
//   cycles T .. T+NBYTES-1   memory port active, one byte per cycle
//   cycle after T+NBYTES     resp_valid pulse (RESP)
//   cycle after T+NBYTES+1   back in IDLE, req_ready high again
// ---------------------------------------------------------------------------
module mem_word_seq #(
    parameter int ADDR_BITS = 8,
    parameter int NBYTES    = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    mem_word_seq_if.slave   bus
);
    localparam int WBITS = 8 * NBYTES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_q;
    logic [2:0]             idx_q;
    logic [ADDR_BITS-1:0]   base_q;
    logic [WBITS-1:0]       wdata_q;

    logic                   ready_q;
    logic                   resp_valid_q;
    logic [WBITS-1:0]       resp_rdata_q;

    logic                   mem_en_q;
    logic                   mem_write_q;
    logic [ADDR_BITS-1:0]   mem_adr_q;
    logic [7:0]             mem_wdata_q;

    logic                   last_byte;
    logic [2:0]             idx_d;

    assign last_byte = (idx_q == 3'(NBYTES - 1));
    assign idx_d     = idx_q + 3'd1;

    // Controller and all outputs live in one registered process so that the
    // memory port and the handshake never see combinational glitches.
    // wdata_q holds the bytes not yet driven, shifted down one byte per
    // cycle, so the next write byte is always in its low 8 bits. The
    // address is recomputed from the stored base so it wraps naturally at
    // 2^ADDR_BITS. The read word is assembled byte by byte in place, which
    // leaves the previous word visible until the first new byte lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            idx_q        <= 3'd0;
            base_q       <= '0;
            wdata_q      <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_en_q     <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_adr_q    <= '0;
            mem_wdata_q  <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        state_q     <= XFER;
                        ready_q     <= 1'b0;
                        idx_q       <= 3'd0;
                        base_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata >> 8;
                        mem_en_q    <= 1'b1;
                        mem_write_q <= bus.req_write;
                        mem_adr_q   <= bus.req_addr;
                        mem_wdata_q <= bus.req_wdata[7:0];
                    end
                end

                XFER: begin
                    resp_rdata_q[8*idx_q +: 8] <= bus.mem_rdata;
                    if (last_byte) begin
                        state_q      <= RESP;
                        idx_q        <= 3'd0;
                        resp_valid_q <= 1'b1;
                        mem_en_q     <= 1'b0;
                        mem_write_q  <= 1'b0;
                        mem_adr_q    <= '0;
                        mem_wdata_q  <= 8'h00;
                    end else begin
                        idx_q       <= idx_d;
                        mem_adr_q   <= base_q + ADDR_BITS'(idx_d);
                        mem_wdata_q <= wdata_q[7:0];
                        wdata_q     <= wdata_q >> 8;
                    end
                end

                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    ready_q      <= 1'b1;
                end

                default: begin
                    state_q      <= IDLE;
                    idx_q        <= 3'd0;
                    ready_q      <= 1'b1;
                    resp_valid_q <= 1'b0;
                    mem_en_q     <= 1'b0;
                    mem_write_q  <= 1'b0;
                    mem_adr_q    <= '0;
                    mem_wdata_q  <= 8'h00;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_adr    = mem_adr_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_word_seq.sv
// ---------------------------------------------------------------------------
// tb_mem_word_seq
//
// Purpose:
//   Drives mem_word_seq with directed and random word transfers against a
//   falling-edge byte memory, and compares every observable output against a
//   word-level reference model (refMem) that applies transfers as whole
//   words, independent of how the sequencer steps through bytes.
// ---------------------------------------------------------------------------
module tb_mem_word_seq;
    localparam int ADDR_BITS = 8;
    localparam int NBYTES    = 4;

    logic clk;
    logic reset_n;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem    [256] = '{default: 8'h00};
    logic [7:0] refMem [256];

    mem_word_seq_if #(.ADDR_BITS(ADDR_BITS), .NBYTES(NBYTES)) bus ();

    mem_word_seq #(.ADDR_BITS(ADDR_BITS), .NBYTES(NBYTES)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory: samples the port on the falling edge and returns the
    // pre-write contents on that same edge.
    always @(negedge clk) begin
        if (bus.mem_en) begin
            bus.mem_rdata <= mem[bus.mem_adr];
            if (bus.mem_write) begin
                mem[bus.mem_adr] <= bus.mem_wdata;
            end
        end
    end

    // One comparison: counts it, and on mismatch counts the failure and
    // reports the tag with observed and expected values.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word-level reference: returns the word currently stored at base
    // (wrapping at 256) and, for writes, stores the new word there.
    function automatic logic [31:0] modelTransfer(input bit wr, input logic [7:0] base, input logic [31:0] wdata);
        logic [31:0] word;
        logic [7:0]  a;
        word = '0;
        for (int i = 0; i < NBYTES; i++) begin
            a = base + 8'(i);
            word[8*i +: 8] = refMem[a];
            if (wr) refMem[a] = wdata[8*i +: 8];
        end
        return word;
    endfunction

    // Complete transfer starting between clock edges with the DUT idle.
    // Checks the memory port every cycle, the response pulse and the return
    // to idle. With hold set, req_valid stays high so the next call is
    // accepted back to back. req_* are scrambled after acceptance.
    task automatic applyStimulus(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                                 input bit hold, output logic [31:0] rdata);
        logic [31:0] expWord;
        logic [7:0]  a;
        expWord = modelTransfer(wr, addr, wdata);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        checkOutput("req_ready_before_accept", 64'(bus.req_ready), 64'(1'b1));
        @(posedge clk); #1;
        bus.req_valid = hold;
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_addr  = 8'($urandom);
        bus.req_wdata = $urandom;
        for (int k = 0; k < NBYTES; k++) begin
            a = addr + 8'(k);
            checkOutput("xfer_mem_en",     64'(bus.mem_en),     64'(1'b1));
            checkOutput("xfer_mem_write",  64'(bus.mem_write),  64'(wr));
            checkOutput("xfer_mem_adr",    64'(bus.mem_adr),    64'(a));
            checkOutput("xfer_mem_wdata",  64'(bus.mem_wdata),  64'(wdata[8*k +: 8]));
            checkOutput("xfer_req_ready",  64'(bus.req_ready),  64'(1'b0));
            checkOutput("xfer_resp_valid", 64'(bus.resp_valid), 64'(1'b0));
            @(posedge clk); #1;
        end
        checkOutput("resp_valid",      64'(bus.resp_valid), 64'(1'b1));
        checkOutput("resp_rdata",      64'(bus.resp_rdata), 64'(expWord));
        checkOutput("resp_mem_en",     64'(bus.mem_en),     64'(1'b0));
        checkOutput("resp_mem_write",  64'(bus.mem_write),  64'(1'b0));
        checkOutput("resp_mem_adr",    64'(bus.mem_adr),    64'(8'h00));
        checkOutput("resp_mem_wdata",  64'(bus.mem_wdata),  64'(8'h00));
        checkOutput("resp_req_ready",  64'(bus.req_ready),  64'(1'b0));
        rdata = bus.resp_rdata;
        @(posedge clk); #1;
        checkOutput("idle_resp_valid", 64'(bus.resp_valid), 64'(1'b0));
        checkOutput("idle_req_ready",  64'(bus.req_ready),  64'(1'b1));
        checkOutput("idle_rdata_hold", 64'(bus.resp_rdata), 64'(expWord));
        checkOutput("idle_mem_en",     64'(bus.mem_en),     64'(1'b0));
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] before42;
        logic [7:0]  ra;
        logic [31:0] rw;
        bit          rwr;
        bit          rhold;

        for (int i = 0; i < 256; i++) refMem[i] = 8'h00;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 32'h0;
        reset_n       = 1'b0;

        // Reset state, with a request already pending.
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_req_ready",  64'(bus.req_ready),  64'(1'b1));
        checkOutput("rst_resp_valid", 64'(bus.resp_valid), 64'(1'b0));
        checkOutput("rst_resp_rdata", 64'(bus.resp_rdata), 64'(32'h0));
        checkOutput("rst_mem_en",     64'(bus.mem_en),     64'(1'b0));
        checkOutput("rst_mem_write",  64'(bus.mem_write),  64'(1'b0));
        checkOutput("rst_mem_adr",    64'(bus.mem_adr),    64'(8'h00));
        checkOutput("rst_mem_wdata",  64'(bus.mem_wdata),  64'(8'h00));
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Load 11,22,33,44 at 0x10 then read it back as one word.
        applyStimulus(1'b1, 8'h10, 32'h44332211, 1'b0, r);
        applyStimulus(1'b0, 8'h10, 32'h0, 1'b0, r);
        checkOutput("read_0x10_word", 64'(r), 64'(32'h44332211));

        // Write over zeros returns zeros, lands little-endian, reads back.
        applyStimulus(1'b1, 8'h20, 32'hDEADBEEF, 1'b0, r);
        checkOutput("write_0x20_preword", 64'(r), 64'(32'h0));
        @(negedge clk);
        checkOutput("mem_0x20", 64'(mem[8'h20]), 64'(8'hEF));
        checkOutput("mem_0x21", 64'(mem[8'h21]), 64'(8'hBE));
        checkOutput("mem_0x22", 64'(mem[8'h22]), 64'(8'hAD));
        checkOutput("mem_0x23", 64'(mem[8'h23]), 64'(8'hDE));
        applyStimulus(1'b0, 8'h20, 32'h0, 1'b0, r);
        checkOutput("read_0x20_word", 64'(r), 64'(32'hDEADBEEF));

        // Address wrap at the top of the byte space.
        applyStimulus(1'b1, 8'hFE, 32'h04030201, 1'b0, r);
        applyStimulus(1'b0, 8'hFE, 32'h0, 1'b0, r);
        checkOutput("read_0xFE_wrap", 64'(r), 64'(32'h04030201));
        @(negedge clk);
        checkOutput("mem_0x00_wrap", 64'(mem[8'h00]), 64'(8'h03));

        // req_valid held high across two reads: accepted back to back,
        // req_addr scrambled mid-transfer inside applyStimulus.
        applyStimulus(1'b0, 8'h10, 32'h0, 1'b1, r);
        checkOutput("b2b_first", 64'(r), 64'(32'h44332211));
        applyStimulus(1'b0, 8'h20, 32'h0, 1'b0, r);
        checkOutput("b2b_second", 64'(r), 64'(32'hDEADBEEF));

        // Reset in the middle of a write of AABBCCDD at 0x40.
        applyStimulus(1'b1, 8'h40, $urandom, 1'b0, r);
        before42 = {refMem[8'h43], refMem[8'h42], refMem[8'h41], refMem[8'h40]};
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h40;
        bus.req_wdata = 32'hAABBCCDD;
        checkOutput("abort_ready", 64'(bus.req_ready), 64'(1'b1));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("abort_third_adr", 64'(bus.mem_adr), 64'(8'h42));
        reset_n = 1'b0;
        #1;
        checkOutput("abort_mem_en",     64'(bus.mem_en),     64'(1'b0));
        checkOutput("abort_mem_write",  64'(bus.mem_write),  64'(1'b0));
        checkOutput("abort_mem_adr",    64'(bus.mem_adr),    64'(8'h00));
        checkOutput("abort_req_ready",  64'(bus.req_ready),  64'(1'b1));
        checkOutput("abort_resp_rdata", 64'(bus.resp_rdata), 64'(32'h0));
        refMem[8'h40] = 8'hDD;
        refMem[8'h41] = 8'hCC;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            checkOutput("abort_no_resp", 64'(bus.resp_valid), 64'(1'b0));
        end
        checkOutput("abort_mem_0x40", 64'(mem[8'h40]), 64'(8'hDD));
        checkOutput("abort_mem_0x41", 64'(mem[8'h41]), 64'(8'hCC));
        checkOutput("abort_mem_0x42", 64'(mem[8'h42]), 64'(before42[23:16]));
        checkOutput("abort_mem_0x43", 64'(mem[8'h43]), 64'(before42[31:24]));
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1'b0, 8'h40, 32'h0, 1'b0, r);
        checkOutput("abort_readback", 64'(r), 64'({before42[31:16], 16'hCCDD}));

        // Random mix of reads/writes, random addresses, random back-to-back.
        for (int n = 0; n < 30; n++) begin
            rwr   = 1'($urandom_range(0, 1));
            ra    = 8'($urandom);
            if (n % 5 == 0) ra = 8'($urandom_range(8'hFD, 8'hFF));
            rw    = $urandom;
            rhold = 1'($urandom_range(0, 1));
            applyStimulus(rwr, ra, rw, rhold, r);
        end
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("final_idle_ready", 64'(bus.req_ready), 64'(1'b1));
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            checkOutput("final_mem_image", 64'(mem[i]), 64'(refMem[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
